// File: rtl/pellet_tracker_if.sv
// Bus bundle between the pellet tracker and its environment: motion input,
// map ROM port, render query port and the score/status outputs.
interface pellet_tracker_if;
    logic        frame_tick;
    logic        restart;
    logic [9:0]  BallX;
    logic [9:0]  BallY;
    logic [10:0] rom_addr;
    logic [1:0]  rom_data;
    logic [5:0]  query_tx;
    logic [4:0]  query_ty;
    logic [1:0]  query_pellet;
    logic [15:0] score;
    logic [10:0] pellets_left;
    logic        power_pulse;
    logic        level_clear;
    logic        ready;

    modport master (
        output frame_tick, restart, BallX, BallY, rom_data, query_tx, query_ty,
        input  rom_addr, query_pellet, score, pellets_left, power_pulse, level_clear, ready
    );

    modport slave (
        input  frame_tick, restart, BallX, BallY, rom_data, query_tx, query_ty,
        output rom_addr, query_pellet, score, pellets_left, power_pulse, level_clear, ready
    );
endinterface

// File: rtl/pellet_tracker.sv
// Live pellet map for the maze: loads from ROM, eats the tile under the player
// once per frame, keeps score / pellets remaining and serves render queries.
module pellet_tracker #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int PELLET_PTS = 10,
    parameter int POWER_PTS  = 50
) (
    input  logic             Clk,
    input  logic             Reset_n,
    pellet_tracker_if.slave  bus
);

    localparam int          MAP_SIZE = MAP_W * MAP_H;
    localparam logic [10:0] K_LAST   = 11'(MAP_SIZE);
    localparam logic [10:0] ADDR_MAX = 11'(MAP_SIZE - 1);
    localparam logic [5:0]  MAP_W_C  = 6'(MAP_W);
    localparam logic [5:0]  MAP_H_C  = 6'(MAP_H);
    localparam logic [4:0]  MAP_H_Q  = 5'(MAP_H);
    localparam logic [16:0] PELLET_C = 17'(PELLET_PTS);
    localparam logic [16:0] POWER_C  = 17'(POWER_PTS);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Row stride of 40 tiles built from two shifts: ty*32 + ty*8 + tx.
    function automatic logic [10:0] tile_addr(input logic [4:0] ty, input logic [5:0] tx);
        return {1'b0, ty, 5'b00000} + {3'b000, ty, 3'b000} + {5'b00000, tx};
    endfunction

    function automatic logic [1:0] clean_code(input logic [1:0] code);
        return (code == 2'd3) ? 2'd0 : code;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [10:0] k_r;
    logic [10:0] rom_addr_r;
    logic [10:0] lat_addr_r;
    logic [1:0]  val_r;
    logic [15:0] score_r;
    logic [10:0] pellets_left_r;
    logic        power_pulse_r;
    logic        level_clear_r;
    logic        ready_r;
    logic [1:0]  query_pellet_r;
    logic [1:0]  map_r [0:MAP_SIZE-1];

    logic [5:0]  ball_tx_s;
    logic [5:0]  ball_ty_s;
    logic        ball_ok_s;
    logic [10:0] ball_addr_s;
    logic        query_ok_s;
    logic [10:0] query_addr_s;
    logic [1:0]  rom_code_s;
    logic [16:0] score_sum_s;
    logic [15:0] score_next_s;
    logic        init_wr_s;
    logic        latch_s;
    logic        eat_s;

    assign ball_tx_s    = 6'(bus.BallX >> TILE_SHIFT);
    assign ball_ty_s    = 6'(bus.BallY >> TILE_SHIFT);
    assign ball_ok_s    = (ball_tx_s < MAP_W_C) && (ball_ty_s < MAP_H_C);
    assign ball_addr_s  = tile_addr(ball_ty_s[4:0], ball_tx_s);
    assign query_ok_s   = (bus.query_tx < MAP_W_C) && (bus.query_ty < MAP_H_Q);
    assign query_addr_s = tile_addr(bus.query_ty, bus.query_tx);
    assign rom_code_s   = clean_code(bus.rom_data);
    assign score_sum_s  = {1'b0, score_r} + ((val_r == 2'd2) ? POWER_C : PELLET_C);
    assign score_next_s = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle strobes; restart pre-empts every state.
    always_comb begin
        state_next_s = state_r;
        init_wr_s    = 1'b0;
        latch_s      = 1'b0;
        eat_s        = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (bus.restart) begin
                    state_next_s = ST_INIT;
                end else begin
                    init_wr_s = (k_r != 11'd0);
                    if (k_r == K_LAST) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_INIT;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.restart) begin
                    state_next_s = ST_INIT;
                end else if (bus.frame_tick && ball_ok_s) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_LOOKUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (bus.restart) begin
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (bus.restart) begin
                    state_next_s = ST_INIT;
                end else begin
                    eat_s        = (val_r != 2'd0);
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Datapath: ROM sweep, eat bookkeeping and the registered query port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            k_r            <= 11'd0;
            rom_addr_r     <= 11'd0;
            lat_addr_r     <= 11'd0;
            val_r          <= 2'd0;
            score_r        <= 16'd0;
            pellets_left_r <= 11'd0;
            power_pulse_r  <= 1'b0;
            level_clear_r  <= 1'b0;
            ready_r        <= 1'b0;
            query_pellet_r <= 2'd0;
        end else begin
            power_pulse_r  <= eat_s && (val_r == 2'd2);
            ready_r        <= (state_next_s != ST_INIT);
            query_pellet_r <= ((state_r != ST_INIT) && query_ok_s) ? map_r[query_addr_s] : 2'd0;
            if (bus.restart) begin
                k_r            <= 11'd0;
                rom_addr_r     <= 11'd0;
                pellets_left_r <= 11'd0;
                level_clear_r  <= 1'b0;
            end else if (state_r == ST_INIT) begin
                if (k_r != K_LAST) begin
                    k_r <= k_r + 11'd1;
                end
                rom_addr_r <= (k_r < ADDR_MAX) ? (k_r + 11'd1) : ADDR_MAX;
                if (init_wr_s && (rom_code_s != 2'd0)) begin
                    pellets_left_r <= pellets_left_r + 11'd1;
                end
            end else begin
                if (latch_s) begin
                    lat_addr_r <= ball_addr_s;
                end
                if (state_r == ST_LOOKUP) begin
                    val_r <= map_r[lat_addr_r];
                end
                if (eat_s) begin
                    pellets_left_r <= pellets_left_r - 11'd1;
                    score_r        <= score_next_s;
                    if (pellets_left_r == 11'd1) begin
                        level_clear_r <= 1'b1;
                    end
                end
            end
        end
    end

    // Map write port: ROM fill during INIT (one cycle behind rom_addr), clear on eat.
    always_ff @(posedge Clk) begin
        if (init_wr_s) begin
            map_r[k_r - 11'd1] <= rom_code_s;
        end else if (eat_s) begin
            map_r[lat_addr_r] <= 2'd0;
        end
    end

    assign bus.rom_addr     = rom_addr_r;
    assign bus.query_pellet = query_pellet_r;
    assign bus.score        = score_r;
    assign bus.pellets_left = pellets_left_r;
    assign bus.power_pulse  = power_pulse_r;
    assign bus.level_clear  = level_clear_r;
    assign bus.ready        = ready_r;

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed plus randomized bench for pellet_tracker against a tile-array model.
module tb_pellet_tracker;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [1:0] rom_mem [0:2047];
    int         m_map [0:1199];
    int         m_score;
    int         m_left;
    bit         m_clear;
    int         next_tile;

    pellet_tracker_if bus ();

    pellet_tracker dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Map ROM with one cycle of read latency.
    always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tile_bx(input int a);
        return (a % 40) * 16 + 8;
    endfunction

    function automatic int tile_by(input int a);
        return (a / 40) * 16 + 8;
    endfunction

    function automatic int m_at(input int tx, input int ty);
        if (tx < 40 && ty < 30) return m_map[ty * 40 + tx];
        return 0;
    endfunction

    task automatic fill_rom(input int code);
        for (int i = 0; i < 2048; i++) rom_mem[i] = (i < 1200) ? 2'(code) : 2'd0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_score"}, bus.score, 0);
        chk({tag, "_left"}, bus.pellets_left, 0);
        chk({tag, "_pulse"}, bus.power_pulse, 0);
        chk({tag, "_clear"}, bus.level_clear, 0);
        chk({tag, "_ready"}, bus.ready, 0);
        chk({tag, "_query"}, bus.query_pellet, 0);
        chk({tag, "_romaddr"}, bus.rom_addr, 0);
    endtask

    // Waits for ready, checks INIT length, then rebuilds the model from the ROM.
    task automatic wait_ready(input string tag);
        int cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (bus.ready !== 1'b1 && cyc < 1400);
        chk({tag, "_init_len"}, cyc, 1201);
        m_left  = 0;
        m_clear = 0;
        for (int i = 0; i < 1200; i++) begin
            m_map[i] = (rom_mem[i] == 2'd3) ? 0 : int'(rom_mem[i]);
            if (m_map[i] != 0) m_left++;
        end
        chk({tag, "_left"}, bus.pellets_left, m_left);
        chk({tag, "_clear"}, bus.level_clear, 0);
    endtask

    task automatic do_restart(input string tag);
        @(negedge Clk);
        bus.restart = 1'b1;
        @(negedge Clk);
        bus.restart = 1'b0;
        chk({tag, "_ready_low"}, bus.ready, 0);
        wait_ready(tag);
    endtask

    task automatic model_eat(input int bx, input int by, output bit pulse);
        int tx = bx >> 4;
        int ty = by >> 4;
        int a;
        pulse = 1'b0;
        if (tx < 40 && ty < 30) begin
            a = ty * 40 + tx;
            if (m_map[a] != 0) begin
                pulse   = (m_map[a] == 2);
                m_score = m_score + (pulse ? 50 : 10);
                if (m_score > 65535) m_score = 65535;
                m_map[a] = 0;
                m_left--;
                if (m_left == 0) m_clear = 1'b1;
            end
        end
    endtask

    task automatic eat(input int bx, input int by);
        int s0 = m_score;
        int l0 = m_left;
        bit pulse;
        model_eat(bx, by, pulse);
        @(negedge Clk);
        bus.BallX      = 10'(bx);
        bus.BallY      = 10'(by);
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        @(negedge Clk);
        chk("eat_e1_score", bus.score, s0);
        chk("eat_e1_left", bus.pellets_left, l0);
        @(negedge Clk);
        chk("eat_score", bus.score, m_score);
        chk("eat_left", bus.pellets_left, m_left);
        chk("eat_pulse", bus.power_pulse, 32'(pulse));
        chk("eat_clear", bus.level_clear, 32'(m_clear));
        @(negedge Clk);
        chk("eat_pulse_off", bus.power_pulse, 0);
    endtask

    task automatic query(input int tx, input int ty, input int exp);
        @(negedge Clk);
        bus.query_tx = 6'(tx);
        bus.query_ty = 5'(ty);
        @(negedge Clk);
        chk("query", bus.query_pellet, exp);
    endtask

    initial begin
        int bx, by, qx, qy, s_hold;
        bit pulse;
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        bus.BallX      = 10'd0;
        bus.BallY      = 10'd0;
        bus.query_tx   = 6'd0;
        bus.query_ty   = 5'd0;
        Reset_n        = 1'b0;
        m_score        = 0;
        fill_rom(1);
        rom_mem[0] = 2'd2;
        rom_mem[5] = 2'd3;

        repeat (3) @(negedge Clk);
        check_reset("rst");
        Reset_n = 1'b1;
        wait_ready("boot");
        chk("boot_left_1199", bus.pellets_left, 1199);
        query(0, 0, 2);
        query(5, 0, 0);

        // Normal pellet at tile (2,1), then the same tile again.
        eat(40, 20);
        chk("first_score", bus.score, 10);
        chk("first_left", bus.pellets_left, 1198);
        query(2, 1, 0);
        eat(40, 20);
        eat(0, 0);
        chk("power_score", bus.score, 60);

        repeat (30) begin
            bx = $urandom_range(0, 719);
            by = $urandom_range(0, 539);
            eat(bx, by);
            qx = $urandom_range(0, 63);
            qy = $urandom_range(0, 31);
            query(qx, qy, m_at(qx, qy));
        end

        // Single pellet in the last tile; out-of-range tick afterwards.
        fill_rom(0);
        rom_mem[1199] = 2'd1;
        do_restart("single");
        chk("single_left", bus.pellets_left, 1);
        eat(630, 470);
        chk("single_clear", bus.level_clear, 1);
        chk("single_left0", bus.pellets_left, 0);
        eat(640, 470);
        chk("single_clear_sticky", bus.level_clear, 1);

        // Drive score toward saturation with an all-power map.
        fill_rom(2);
        do_restart("sat");
        next_tile = 0;
        while (m_score <= 65485) begin
            if (next_tile == 1200) begin
                chk("full_map_clear", bus.level_clear, 1);
                do_restart("sat2");
                next_tile = 0;
            end
            eat(tile_bx(next_tile), tile_by(next_tile));
            next_tile++;
        end
        eat(tile_bx(next_tile), tile_by(next_tile));
        next_tile++;
        chk("sat_score", bus.score, 32'hFFFF);

        // frame_tick on three consecutive cycles over three different tiles.
        model_eat(tile_bx(next_tile), tile_by(next_tile), pulse);
        @(negedge Clk);
        bus.BallX      = 10'(tile_bx(next_tile));
        bus.BallY      = 10'(tile_by(next_tile));
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.BallX = 10'(tile_bx(next_tile + 1));
        bus.BallY = 10'(tile_by(next_tile + 1));
        @(negedge Clk);
        bus.BallX = 10'(tile_bx(next_tile + 2));
        bus.BallY = 10'(tile_by(next_tile + 2));
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        chk("burst_pulse", bus.power_pulse, 32'(pulse));
        repeat (4) @(negedge Clk);
        chk("burst_left", bus.pellets_left, m_left);
        chk("burst_score", bus.score, m_score);
        query((next_tile + 1) % 40, (next_tile + 1) / 40, 2);
        query((next_tile + 2) % 40, (next_tile + 2) / 40, 2);

        // restart while the eat sits in LOOKUP.
        fill_rom(1);
        do_restart("reload");
        s_hold = m_score;
        @(negedge Clk);
        bus.BallX      = 10'(tile_bx(42));
        bus.BallY      = 10'(tile_by(42));
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b1;
        @(negedge Clk);
        bus.restart = 1'b0;
        chk("abort_ready", bus.ready, 0);
        chk("abort_score", bus.score, s_hold);
        wait_ready("abort");
        chk("abort_score_kept", bus.score, s_hold);
        chk("abort_left", bus.pellets_left, 1200);
        query(2, 1, 1);

        // Asynchronous reset in the middle of INIT, then a random map.
        for (int i = 0; i < 1200; i++) rom_mem[i] = 2'($urandom_range(0, 3));
        @(negedge Clk);
        bus.restart = 1'b1;
        @(negedge Clk);
        bus.restart = 1'b0;
        repeat (500) @(negedge Clk);
        query(0, 0, 0);
        Reset_n = 1'b0;
        #1;
        check_reset("midinit");
        m_score = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        wait_ready("rand_map");
        repeat (30) begin
            bx = $urandom_range(0, 719);
            by = $urandom_range(0, 539);
            eat(bx, by);
            qx = $urandom_range(0, 63);
            qy = $urandom_range(0, 31);
            query(qx, qy, m_at(qx, qy));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pellet_tracker.md
Name: pellet_tracker

Overview:
- Downstream consumer of the player-motion block's BallX/BallY outputs. Each frame it converts the player centre to a 16x16-px maze tile and eats any pellet on that tile.
- Owns the live pellet map: 40x30 tiles, 2 bits per tile.
- Maintains score and the pellets-remaining count, flags power pellets and level clear.
- Serves a registered read port to the sprite/colour mapper.

Parameters:
- TILE_SHIFT, 4, log2 of tile size in pixels
- MAP_W, 40, tiles per row
- MAP_H, 30, tile rows
- PELLET_PTS, 10, score added for a normal pellet
- POWER_PTS, 50, score added for a power pellet

Ports:
- Clk  in  1  system clock; all state on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per video frame
- restart  in  1  one-Clk pulse; reload the map from ROM, score kept
- BallX  in  10  player centre X, pixels
- BallY  in  10  player centre Y, pixels
- rom_addr  out  11  initial-map ROM address
- rom_data  in  2  ROM tile code, one-cycle latency: 0 empty, 1 pellet, 2 power, 3 treated as empty
- query_tx  in  6  render read tile X
- query_ty  in  5  render read tile Y
- query_pellet  out  2  tile code at (query_tx, query_ty), registered
- score  out  16  accumulated score
- pellets_left  out  11  count of nonzero tiles remaining
- power_pulse  out  1  one-cycle pulse when a power pellet is eaten
- level_clear  out  1  sticky; high once pellets_left reaches 0 by eating
- ready  out  1  high in IDLE and the eat states; low during INIT

Behaviour:
- Reset state (Reset_n low, asynchronous):
  - Outputs: score=0, pellets_left=0, power_pulse=0, level_clear=0, ready=0, query_pellet=0, rom_addr=0.
  - FSM enters INIT. Map contents are undefined until INIT completes.
- Address arithmetic:
  - addr = ty*40 + tx, computed as (ty<<5)+(ty<<3)+tx at 11 bits.
  - Maximum address is 1199.
  - Tile coordinates: tx = BallX>>TILE_SHIFT, ty = BallY>>TILE_SHIFT.
- States:
  - INIT:
    - Counter k steps 0..1199 and drives rom_addr=k.
    - On each edge after the first, the cycle's rom_data is written to addr k-1. pellets_left increments when that data is 1 or 2; code 3 is written as 0.
    - After writing addr 1199, go to IDLE.
    - INIT lasts 1201 cycles. ready=0 throughout. level_clear is cleared on entry.
  - IDLE:
    - On frame_tick, register the tile address. Go to LOOKUP.
    - If tx>=MAP_W or ty>=MAP_H, ignore the tick and stay in IDLE.
  - LOOKUP: register the map value at the latched address. Go to UPDATE.
  - UPDATE, if the value is nonzero:
    - Write 0 to the tile.
    - pellets_left -= 1.
    - score += PELLET_PTS, or POWER_PTS for code 2. score saturates at 16'hFFFF.
    - power_pulse=1 for this edge only, code 2 only.
    - If pellets_left goes from 1 to 0, set level_clear.
    - Always return to IDLE.
- Eat latency: if frame_tick is sampled on edge E, the outputs change on edge E+2, and the tile reads 0 from edge E+2 onward.
- frame_tick arriving in LOOKUP, UPDATE or INIT is dropped, not queued.
- restart:
  - From any state other than INIT, restart enters INIT on the next edge, aborting any eat in flight (no score change).
  - pellets_left is zeroed and recounted. score is retained.
  - restart during INIT restarts INIT from k=0.
- Query port:
  - query_pellet is registered, with 1-cycle latency.
  - Returns 0 for out-of-range coordinates and for all reads during INIT.
  - A query and an UPDATE write to the same tile in the same cycle return the old value. The new value appears on the next read.
- Asynchronous reset asserted mid-INIT or mid-eat: immediate return to reset values, and INIT runs again after release.

Test Plan:
- Reset release with ROM of all 1s except addr 0 = 2 and addr 5 = 3 -> ready rises 1201 cycles after release; pellets_left=1199; query (0,0)=2, query (5,0)=0.
- After init, BallX=40, BallY=20 (tile 2,1 = addr 42, code 1), one frame_tick -> score=10 and pellets_left=1198 on edge E+2; query (2,1)=0; a second tick on the same tile changes nothing.
- Player on addr 0 (code 2), tick -> score +50, power_pulse high exactly 1 cycle, pellets_left -1.
- ROM with a single pellet at addr 1199; BallX=630, BallY=470, tick -> pellets_left=0, level_clear=1 and sticky. BallX=640, tick -> ignored, no state change.
- score preset near 16'hFFF8 via repeated eats, then a power pellet is eaten -> score=16'hFFFF; frame_tick pulses on consecutive cycles -> only the first is acted on.
- restart pulsed in LOOKUP over a pellet -> no score change, ready falls, map reloads, level_clear=0, score retained. Reset_n low mid-INIT -> all outputs at reset values immediately.
